// File: rtl/gt_serial.sv
// Bit-serial unsigned a > b comparator: LSB-first, one bit per cycle, valid/ready on both sides.
// Optional macro GT_SERIAL_EQ_EN adds an equality output (eq) tracked alongside gt.
module gt_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
`ifdef GT_SERIAL_EQ_EN
  output logic             eq,
`endif
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              carry_q, carry_d, carry_step;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              gt_q, gt_d;
`ifdef GT_SERIAL_EQ_EN
  logic              eq_run_q, eq_run_d, eq_step;
  logic              eq_q, eq_d;
`endif

  // A bit where a and b differ overrides whatever the lower bits decided.
  assign carry_step = (a_q[0] & ~b_q[0]) | (~(~a_q[0] & b_q[0]) & carry_q);
`ifdef GT_SERIAL_EQ_EN
  assign eq_step    = eq_run_q & (a_q[0] ~^ b_q[0]);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
`ifdef GT_SERIAL_EQ_EN
    eq_run_d = eq_run_q;
    eq_d     = eq_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef GT_SERIAL_EQ_EN
          eq_run_d = 1'b1;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        carry_d = carry_step;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
`ifdef GT_SERIAL_EQ_EN
        eq_run_d = eq_step;
`endif
        // Last bit: publish the result and hold the counter rather than wrap it.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          gt_d    = carry_step;
`ifdef GT_SERIAL_EQ_EN
          eq_d    = eq_step;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
`ifdef GT_SERIAL_EQ_EN
      eq_run_q <= 1'b0;
      eq_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
`ifdef GT_SERIAL_EQ_EN
      eq_run_q <= eq_run_d;
      eq_q     <= eq_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign gt        = gt_q;
`ifdef GT_SERIAL_EQ_EN
  assign eq        = eq_q;
`endif

endmodule

// File: tb/tb_gt_serial.sv
// Scoreboard bench for gt_serial: drivers push expected {gt,eq}, negedge monitors pop and compare.
// Covers WIDTH=4 (directed, stall, reset, random) and WIDTH=8 (directed, random).
module tb_gt_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv4 = 1'b0, ir4, ov4, ordy4 = 1'b1, gt4, busy4;
  logic [3:0] a4 = '0, b4 = '0;
  logic       iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, gt8, busy8;
  logic [7:0] a8 = '0, b8 = '0;
`ifdef GT_SERIAL_EQ_EN
  logic       eq4, eq8;
`endif

  gt_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(ordy4), .gt(gt4),
`ifdef GT_SERIAL_EQ_EN
    .eq(eq4),
`endif
    .busy(busy4)
  );

  gt_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8), .gt(gt8),
`ifdef GT_SERIAL_EQ_EN
    .eq(eq8),
`endif
    .busy(busy8)
  );

  int tests = 0;
  int fails = 0;
  logic [1:0] q4[$];
  logic [1:0] q8[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: a result is consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && ov4 && ordy4) begin
      if (q4.size() == 0) chk("w4_unexpected_result", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("w4_gt", {31'd0, gt4}, {31'd0, e[1]});
`ifdef GT_SERIAL_EQ_EN
        chk("w4_eq", {31'd0, eq4}, {31'd0, e[0]});
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && ov8 && ordy8) begin
      if (q8.size() == 0) chk("w8_unexpected_result", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("w8_gt", {31'd0, gt8}, {31'd0, e[1]});
`ifdef GT_SERIAL_EQ_EN
        chk("w8_eq", {31'd0, eq8}, {31'd0, e[0]});
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send4(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    iv4 = 1'b1; a4 = x; b4 = y;
    while (!ir4 && n < 50) begin @(posedge clk); #1; n++; end
    if (!ir4) begin
      chk("w4_in_ready_timeout", 32'd0, 32'd1);
      iv4 = 1'b0;
    end else begin
      q4.push_back({x > y, x == y});
      @(posedge clk); #1;
      iv4 = 1'b0;
    end
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    iv8 = 1'b1; a8 = x; b8 = y;
    while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
    if (!ir8) begin
      chk("w8_in_ready_timeout", 32'd0, 32'd1);
      iv8 = 1'b0;
    end else begin
      q8.push_back({x > y, x == y});
      @(posedge clk); #1;
      iv8 = 1'b0;
    end
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < lim) begin @(posedge clk); #1; n++; end
    chk("drain_q4_empty", q4.size(), 32'd0);
    chk("drain_q8_empty", q8.size(), 32'd0);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic [7:0] sa, sb;
    int n;
    #2;
    chk("rst_in_ready", {31'd0, ir4}, 32'd1);
    chk("rst_out_valid", {31'd0, ov4}, 32'd0);
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_gt", {31'd0, gt4}, 32'd0);
`ifdef GT_SERIAL_EQ_EN
    chk("rst_eq", {31'd0, eq4}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency: out_valid after edge E0+4, busy throughout RUN.
    send4(4'hA, 4'h5);
    for (int i = 1; i < 4; i++) begin
      chk("lat_ov_low", {31'd0, ov4}, 32'd0);
      chk("lat_busy_run", {31'd0, busy4}, 32'd1);
      chk("lat_in_ready_run", {31'd0, ir4}, 32'd0);
      @(posedge clk); #1;
    end
    chk("lat_ov_low_last", {31'd0, ov4}, 32'd0);
    @(posedge clk); #1;
    chk("lat_ov_high", {31'd0, ov4}, 32'd1);
    chk("lat_busy_done", {31'd0, busy4}, 32'd1);

    send4(4'h7, 4'h8);
    send4(4'hF, 4'hF);
    send4(4'h0, 4'hF);
    send4(4'h1, 4'h0);
    drain(50);

    // Stall in DONE with new operands offered; nothing may be captured.
    ordy4 = 1'b0;
    send4(4'h8, 4'h7);
    n = 0;
    while (!ov4 && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall_reach_done", {31'd0, ov4}, 32'd1);
    iv4 = 1'b1; a4 = 4'h0; b4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_ov", {31'd0, ov4}, 32'd1);
      chk("stall_gt", {31'd0, gt4}, 32'd1);
      chk("stall_in_ready", {31'd0, ir4}, 32'd0);
    end
    iv4 = 1'b0;
    ordy4 = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_ov", {31'd0, ov4}, 32'd0);
    chk("stall_release_ir", {31'd0, ir4}, 32'd1);
    chk("stall_gt_retained", {31'd0, gt4}, 32'd1);

    // Reset two cycles into RUN discards the operation.
    send4(4'h9, 4'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    q4.delete();
    chk("midrst_ov", {31'd0, ov4}, 32'd0);
    chk("midrst_ir", {31'd0, ir4}, 32'd1);
    chk("midrst_gt", {31'd0, gt4}, 32'd0);
    chk("midrst_busy", {31'd0, busy4}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("postrst_no_result", {31'd0, ov4}, 32'd0);
    end
    send4(4'h3, 4'h2);
    drain(50);

    // Back-to-back random pairs.
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      if (i % 16 == 0) rb = ra;
      send4(ra, rb);
    end
    drain(50);

    send8(8'h80, 8'h7F);
    send8(8'h7F, 8'h80);
    send8(8'hFF, 8'hFF);
    send8(8'h00, 8'h01);
    for (int i = 0; i < 1000; i++) begin
      sa = 8'($urandom); sb = 8'($urandom);
      if (i % 16 == 0) sb = sa;
      send8(sa, sb);
    end
    drain(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gt_serial.md
GT_SERIAL -- requirements
Module: gt_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1: operand pair a/b present.
REQ-005 The block SHALL have port in_ready, output, 1: block accepts an operand pair this cycle.
REQ-006 The block SHALL have port a, input, WIDTH: unsigned operand A.
REQ-007 The block SHALL have port b, input, WIDTH: unsigned operand B.
REQ-008 The block SHALL have port out_valid, output, 1: result valid.
REQ-009 The block SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 The block SHALL have port gt, output, 1: 1 iff a > b (unsigned) for the accepted pair.
REQ-011 The block SHALL have port busy, output, 1: high in RUN and DONE.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE, encoded in a registered state variable.
REQ-013 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-014 A transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; it captures a and b into shift registers, clears the carry register to 0, clears the bit counter to 0, and enters RUN.
REQ-015 In RUN, each cycle SHALL consume the LSBs a0, b0: carry <= (a0 & ~b0) | (~(~a0 & b0) & carry); both shift registers shift right by one; the counter increments.
REQ-016 Bits SHALL be processed LSB-first, so the highest differing bit decides the result; equal bits propagate carry unchanged.
REQ-017 When the counter equals WIDTH-1 in RUN, the final carry SHALL be written to gt and the FSM SHALL enter DONE.
REQ-018 Latency: if the transfer occurs at edge E0, out_valid SHALL rise after edge E0+WIDTH; there is exactly WIDTH cycles in RUN.
REQ-019 In DONE, out_valid SHALL be 1 and gt SHALL hold stable until an edge with out_ready=1, after which the FSM SHALL return to IDLE with out_valid=0.
REQ-020 out_ready=0 in DONE SHALL stall indefinitely without corrupting gt.
REQ-021 in_valid asserted in RUN or DONE SHALL be ignored; a, b SHALL NOT be sampled outside the transfer edge.
REQ-022 out_ready outside DONE SHALL have no effect.
REQ-023 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap inside RUN.
REQ-024 gt SHALL retain its last value in IDLE and RUN until the next DONE entry overwrites it.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, gt=0, carry=0, counter=0, shift registers=0, regardless of the current state, including mid-RUN.
REQ-026 A reset during RUN or DONE SHALL discard the operation; no out_valid SHALL be produced for it.
REQ-027 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro GT_SERIAL_EQ_EN SHALL, when defined, add output port eq (1 bit, after gt): 1 iff a == b for the accepted pair.
REQ-029 With GT_SERIAL_EQ_EN, an eq-tracking register SHALL be set to 1 on transfer and updated in RUN as eq_r <= eq_r & (a0 ~^ b0); eq SHALL be written, held and reset to 0 exactly like gt.
REQ-030 Without GT_SERIAL_EQ_EN, port eq and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 WIDTH=4, a=4'hA, b=4'h5, out_ready=1 -> out_valid high 4 cycles after transfer, gt=1 (eq=0).
REQ-032 a=4'h8, b=4'h7 -> gt=1 (MSB overrides lower bits); a=4'h7, b=4'h8 -> gt=0.
REQ-033 a=4'hF, b=4'hF -> gt=0, eq=1 when GT_SERIAL_EQ_EN is defined; a=4'h0, b=4'hF -> gt=0, eq=0.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> out_valid, gt stable, in_ready=0, new operands not captured; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst_n=0 after 2 RUN cycles -> same-cycle out_valid=0, in_ready=1, gt=0; no result emitted; a post-reset transfer a=4'h3, b=4'h2 -> gt=1.
REQ-036 Back-to-back random pairs, 1000 iterations, WIDTH=4 and WIDTH=8 -> gt matches (a>b) and eq matches (a==b) for every transaction.
